// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU adder: saturate, flag, buffer, count overflows.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; 1 result/cycle.
// Backpressure: in_ready = !full (no comb out_ready->in_ready path); held low during rst.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready/in_sum 6-bit signed adder sum handshake
//   out_valid/out_ready      head-of-buffer handshake
//   out_sum/res/z/n/v        head entry: raw sum, saturated 4-bit result, flags
//   sticky_v, clr_sticky     sticky overflow flag and its clear
//   ovf_count                saturating count of accepted overflowing results
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_sum,
  output logic [3:0]       out_res,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [5:0] sum;
    logic [3:0] res;
    logic       z;
    logic       n;
    logic       v;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     occ_q, occ_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  entry_t in_entry;
  entry_t head;
  logic   full;
  logic   push;
  logic   pop;
  logic   in_range;

  // A 6-bit value fits in 4 signed bits exactly when bits [5:3] are all equal.
  always_comb begin
    in_range     = (in_sum[5:3] == 3'b000) || (in_sum[5:3] == 3'b111);
    in_entry     = '0;
    in_entry.sum = in_sum;
    in_entry.z   = (in_sum == 6'd0);
    in_entry.n   = in_sum[5];
    in_entry.v   = !in_range;
    if (in_range) begin
      in_entry.res = in_sum[3:0];
    end else if (in_sum[5]) begin
      in_entry.res = 4'b1000;
    end else begin
      in_entry.res = 4'b0111;
    end
  end

  always_comb begin
    full      = (occ_q == OCC_FULL);
    in_ready  = !full && !rst;
    out_valid = (occ_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !rst;
    head      = mem_q[rd_ptr_q];
    // Fields read as zero while empty so stale slots never leak out.
    out_sum   = out_valid ? head.sum : 6'd0;
    out_res   = out_valid ? head.res : 4'd0;
    out_z     = out_valid && head.z;
    out_n     = out_valid && head.n;
    out_v     = out_valid && head.v;
    sticky_v  = sticky_q;
    ovf_count = ovf_cnt_q;
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    sticky_d  = sticky_q;
    ovf_cnt_d = ovf_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_ONE;
    end

    // Set beats clear when both happen in the same cycle.
    if (push && in_entry.v) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end

    if (push && in_entry.v && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      sticky_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      sticky_q  <= sticky_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 5-bit signed adder in the 4-bit ALU datapath.
- Accepts the adder's 6-bit signed sum with a valid/ready handshake.
- Derives 4-bit saturated result, zero/negative/overflow flags, a sticky overflow bit and an overflow event counter.
- Buffers results in a small FIFO so the ALU can keep issuing while the consumer stalls.

Parameters:
- DEPTH, 2, number of result entries buffered; power of two, ≥2.
- CNT_W, 8, width of overflow event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_sum carries a result this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_sum  input  6  signed adder sum, two's complement, range -32..+31.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes head entry this cycle.
- out_sum  output  6  head entry full-width signed sum.
- out_res  output  4  head entry signed result saturated to -8..+7.
- out_z  output  1  head entry: in_sum == 0.
- out_n  output  1  head entry: in_sum[5].
- out_v  output  1  head entry: in_sum outside -8..+7.
- sticky_v  output  1  set by any accepted result with v=1.
- clr_sticky  input  1  clears sticky_v.
- ovf_count  output  CNT_W  number of accepted results with v=1, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO emptied (read/write pointers and occupancy count = 0).
  - out_valid=0; out_sum, out_res, out_z, out_n, out_v = 0.
  - sticky_v=0, ovf_count=0.
  - in_ready=0 while rst is high; in_ready=1 the cycle after rst deasserts.
- Reset mid-operation discards all buffered entries. No output handshake completes in a reset cycle.
- Accept: push = in_valid & in_ready. in_ready = !full (occupancy < DEPTH). There is no combinational out_ready→in_ready path.
- Flags are computed combinationally from in_sum at accept time and stored with the entry:
  - z = (in_sum==0).
  - n = in_sum[5].
  - v = (in_sum > 7) | (in_sum < -8).
  - res = 7 if in_sum > 7; -8 if in_sum < -8; else in_sum[3:0].
- Pop: pop = out_valid & out_ready. out_valid = occupancy != 0. Output fields are driven from the head entry; they hold when out_ready=0.
- Latency: a result accepted at edge k is visible on out_* with out_valid=1 after edge k when the FIFO was empty. Throughput is 1 result/cycle with out_ready held high.
- Simultaneous push and pop:
  - Allowed when not full and not empty; occupancy is unchanged.
  - When empty, a same-cycle pop is impossible (out_valid=0).
  - When full, push is blocked (in_ready=0) even if out_ready=1; in_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. Occupancy is tracked in a $clog2(DEPTH)+1-bit counter.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- sticky_v:
  - Set on a push with v=1.
  - Cleared by clr_sticky=1.
  - Same cycle: set wins.
  - Unaffected by pop.
- ovf_count: +1 on each push with v=1. Saturates at 2^CNT_W-1 with no wrap. Cleared only by rst.
- in_sum is ignored when in_valid=0 or in_ready=0. The upstream holds in_sum/in_valid stable until accepted.

Test Plan:
- Reset then idle:
  - rst high 2 cycles, then low → out_valid=0, sticky_v=0, ovf_count=0; in_ready=0 during reset, 1 the cycle after.
- Flag/saturation sweep, out_ready=1:
  - in_sum=0 → res=0, z=1, n=0, v=0.
  - in_sum=7 → res=7, v=0.
  - in_sum=8 → res=7, v=1.
  - in_sum=-8 → res=-8 (4'b1000), n=1, v=0.
  - in_sum=-9 → res=-8, v=1.
  - in_sum=31 → res=7, v=1; in_sum=-32 → res=-8, v=1.
  - Each result appears one cycle after accept.
- Backpressure:
  - out_ready=0, push 3,5,6 back-to-back → after 2 accepts in_ready=0; 6 held at input.
  - Raise out_ready → outputs 3, then 5, then 6 in order; in_ready returns 1 the cycle after the first pop.
- Streaming:
  - in_valid=1 and out_ready=1 for 10 cycles with sums 0..9 → one output per cycle, order preserved.
  - ovf_count=2 (for 8 and 9); sticky_v=1.
- Sticky/counter edges:
  - clr_sticky=1 in the same cycle as an accepted in_sum=12 → sticky_v=1.
  - 300 overflow pushes → ovf_count=255.
- Reset mid-stream:
  - Fill 2 entries, assert rst one cycle → out_valid=0, occupancy 0.
  - Subsequent push of 4 emerges as the first output.
